// File: rtl/count_event_monitor_if.sv
// Event port between the count monitor (master) and the control/logging stage (slave).
// One-entry valid/ready slot carrying an event code and the sampled count value.
interface count_event_monitor_if #(
  parameter int WIDTH = 8
);
  logic             evt_valid;
  logic             evt_ready;
  logic [2:0]       evt_code;
  logic [WIDTH-1:0] evt_value;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_value,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_value,
    output evt_ready
  );
endinterface

// File: rtl/count_event_monitor.sv
// Observes an up/down counter and reports wrap, threshold, stall and direction events
// through a one-entry valid/ready slot, with a saturating wrap counter and sticky drop flag.
module count_event_monitor #(
  parameter int WIDTH        = 8,
  parameter int STALL_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      thresh,
  count_event_monitor_if.master evt,
  output logic [7:0]            wrap_cnt,
  output logic                  stalled,
  output logic                  drop
);

  localparam logic [2:0]       CODE_WRAP_UP = 3'd1;
  localparam logic [2:0]       CODE_WRAP_DN = 3'd2;
  localparam logic [2:0]       CODE_THRESH  = 3'd3;
  localparam logic [2:0]       CODE_STALL   = 3'd4;
  localparam logic [2:0]       CODE_DIR     = 3'd5;
  localparam logic [WIDTH-1:0] ALL_ONES     = '1;
  localparam logic [WIDTH-1:0] ALL_ZEROS    = '0;
  localparam logic [7:0]       STALL_LIMIT  = 8'(STALL_CYCLES);
  localparam logic [7:0]       STALL_ARMED  = 8'(STALL_CYCLES - 1);
  localparam logic [7:0]       SAT_MAX      = 8'hFF;

  // Detection vector, index 4 is the highest priority.
  localparam int DET_WRAP_UP = 4;
  localparam int DET_WRAP_DN = 3;
  localparam int DET_THRESH  = 2;
  localparam int DET_STALL   = 1;
  localparam int DET_DIR     = 0;

  logic [WIDTH-1:0] prev_count_reg, prev_count_next;
  logic             prev_mode_reg,  prev_mode_next;
  logic             prev_vld_reg,   prev_vld_next;
  logic [7:0]       stall_cnt_reg,  stall_cnt_next;
  logic             stalled_reg,    stalled_next;
  logic [7:0]       wrap_cnt_reg,   wrap_cnt_next;
  logic             drop_reg,       drop_next;
  logic             evt_valid_reg,  evt_valid_next;
  logic [2:0]       evt_code_reg,   evt_code_next;
  logic [WIDTH-1:0] evt_value_reg,  evt_value_next;

  logic             same;
  logic [4:0]       det;
  logic [4:0]       higher;
  logic [4:0]       win;
  logic             any_det;
  logic             extra_det;
  logic             slot_free;
  logic             handshake;
  logic [2:0]       win_code;

  assign same = (count == prev_count_reg);

  assign det[DET_WRAP_UP] = prev_vld_reg && (prev_count_reg == ALL_ONES) && (count == ALL_ZEROS);
  assign det[DET_WRAP_DN] = prev_vld_reg && (prev_count_reg == ALL_ZEROS) && (count == ALL_ONES);
  assign det[DET_THRESH]  = prev_vld_reg && (count == thresh) && (prev_count_reg != thresh);
  // Stall fires only on the compare that takes the run length onto the limit.
  assign det[DET_STALL]   = prev_vld_reg && same && (stall_cnt_reg == STALL_ARMED);
  assign det[DET_DIR]     = prev_vld_reg && (mode != prev_mode_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_prio
      assign higher[gi] = |(det >> (gi + 1));
      assign win[gi]    = det[gi] & ~higher[gi];
    end
  endgenerate

  assign any_det   = |det;
  assign extra_det = |(det & ~win);
  assign handshake = evt_valid_reg && evt.evt_ready;
  assign slot_free = !evt_valid_reg || evt.evt_ready;

  always_comb begin
    win_code = 3'd0;
    if (win[DET_WRAP_UP])      win_code = CODE_WRAP_UP;
    else if (win[DET_WRAP_DN]) win_code = CODE_WRAP_DN;
    else if (win[DET_THRESH])  win_code = CODE_THRESH;
    else if (win[DET_STALL])   win_code = CODE_STALL;
    else if (win[DET_DIR])     win_code = CODE_DIR;
  end

  always_comb begin
    prev_count_next = count;
    prev_mode_next  = mode;
    prev_vld_next   = 1'b1;
    stall_cnt_next  = stall_cnt_reg;
    stalled_next    = stalled_reg;
    wrap_cnt_next   = wrap_cnt_reg;
    drop_next       = drop_reg;
    evt_valid_next  = evt_valid_reg;
    evt_code_next   = evt_code_reg;
    evt_value_next  = evt_value_reg;

    if (prev_vld_reg && same) begin
      if (stall_cnt_reg != SAT_MAX) begin
        stall_cnt_next = stall_cnt_reg + 8'd1;
      end
    end else begin
      stall_cnt_next = 8'd0;
    end

    if (det[DET_STALL]) begin
      stalled_next = 1'b1;
    end else if (!same) begin
      stalled_next = 1'b0;
    end

    // Wraps are counted whether or not the event itself makes it into the slot.
    if ((det[DET_WRAP_UP] || det[DET_WRAP_DN]) && (wrap_cnt_reg != SAT_MAX)) begin
      wrap_cnt_next = wrap_cnt_reg + 8'd1;
    end

    if (slot_free && any_det) begin
      evt_valid_next = 1'b1;
      evt_code_next  = win_code;
      evt_value_next = count;
    end else if (handshake) begin
      evt_valid_next = 1'b0;
    end

    if (extra_det || (any_det && !slot_free)) begin
      drop_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_count_reg <= '0;
      prev_mode_reg  <= 1'b0;
      prev_vld_reg   <= 1'b0;
      stall_cnt_reg  <= 8'd0;
      stalled_reg    <= 1'b0;
      wrap_cnt_reg   <= 8'd0;
      drop_reg       <= 1'b0;
      evt_valid_reg  <= 1'b0;
      evt_code_reg   <= 3'd0;
      evt_value_reg  <= '0;
    end else begin
      prev_count_reg <= prev_count_next;
      prev_mode_reg  <= prev_mode_next;
      prev_vld_reg   <= prev_vld_next;
      stall_cnt_reg  <= stall_cnt_next;
      stalled_reg    <= stalled_next;
      wrap_cnt_reg   <= wrap_cnt_next;
      drop_reg       <= drop_next;
      evt_valid_reg  <= evt_valid_next;
      evt_code_reg   <= evt_code_next;
      evt_value_reg  <= evt_value_next;
    end
  end

  assign evt.evt_valid = evt_valid_reg;
  assign evt.evt_code  = evt_code_reg;
  assign evt.evt_value = evt_value_reg;
  assign wrap_cnt      = wrap_cnt_reg;
  assign stalled       = stalled_reg;
  assign drop          = drop_reg;

  // The STALL_LIMIT constant documents the run length the armed compare targets.
  logic unused_ok;
  assign unused_ok = &{1'b0, STALL_LIMIT};

endmodule
